// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
// Optional feature macro: ROB_CDB_COMMIT_BYPASS_EN (same-cycle CDB->commit bypass).
package rob_pkg;

    localparam int WAYS_DEF     = 4;
    localparam int ROB_SIZE_DEF = 32;
    localparam int PRF_DEF      = 64;
    localparam int ROB_W        = $clog2(ROB_SIZE_DEF);
    localparam int PRF_W        = $clog2(PRF_DEF);

    // One ROB slot; complete/mispredict are only meaningful while valid=1.
    typedef struct packed {
        logic             valid;
        logic             complete;
        logic             mispredict;
        logic             has_dest;
        logic [4:0]       arf_idx;
        logic [PRF_W-1:0] prf_idx;
    } rob_entry_t;

    // Population count of a request/commit mask (masks are at most 32 bits).
    function automatic int unsigned count_ones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// In-order retire mask and flush decision over the WAYS-entry head window.
// Bypass inputs are ORed into complete/mispredict; they are zero unless the
// ROB_CDB_COMMIT_BYPASS_EN feature is built in the top.
module rob_commit_select #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] complete,
    input  logic [WAYS-1:0] mispredict,
    input  logic [WAYS-1:0] has_dest,
    input  logic [WAYS-1:0] byp_complete,
    input  logic [WAYS-1:0] byp_mispredict,
    output logic [WAYS-1:0] commit_valid,
    output logic [WAYS-1:0] commit_wr_en,
    output logic            except
);

    logic go;
    logic ready;
    logic mp;

    // Walk the window oldest-first; stop at the first not-ready entry or
    // right after a mispredicted branch (which itself still retires).
    always_comb begin
        commit_valid = '0;
        except       = 1'b0;
        go           = 1'b1;
        ready        = 1'b0;
        mp           = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            ready = valid[j] & (complete[j] | byp_complete[j]);
            mp    = mispredict[j] | byp_mispredict[j];
            if (go && ready) begin
                commit_valid[j] = 1'b1;
                if (mp) begin
                    except = 1'b1;
                    go     = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        commit_wr_en = commit_valid & has_dest;
    end

endmodule

// File: rtl/rob.sv
// Superscalar reorder buffer feeding the RRAT commit bus.
// Optional feature macro: ROB_CDB_COMMIT_BYPASS_EN -- CDB tags hitting the
// head window become commit-eligible in the same cycle.
// ROB_SIZE/PRF overrides must keep the package entry layout consistent.
module rob
    import rob_pkg::*;
#(
    parameter int  WAYS     = WAYS_DEF,
    parameter int  ROB_SIZE = ROB_SIZE_DEF,
    parameter int  PRF      = PRF_DEF,
    localparam int IW       = $clog2(ROB_SIZE),
    localparam int PW       = $clog2(PRF)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WAYS-1:0]        dispatch_valid,
    input  logic [WAYS-1:0]        dispatch_has_dest,
    input  logic [WAYS-1:0][4:0]   dispatch_arf_idx,
    input  logic [WAYS-1:0][PW-1:0] dispatch_prf_idx,
    output logic [WAYS-1:0]        dispatch_accept,
    output logic [WAYS-1:0][IW-1:0] dispatch_rob_idx,
    output logic [IW:0]            free_count,
    input  logic [WAYS-1:0]        cdb_valid,
    input  logic [WAYS-1:0][IW-1:0] cdb_rob_idx,
    input  logic [WAYS-1:0]        cdb_mispredict,
    output logic [WAYS-1:0]        commit_valid,
    output logic [WAYS-1:0]        commit_wr_en,
    output logic [WAYS-1:0][4:0]   commit_arf_idx,
    output logic [WAYS-1:0][PW-1:0] commit_prf_idx,
    output logic                   except
);

    rob_entry_t entries [ROB_SIZE];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   count;
    logic [IW:0]   n_req;
    logic [IW:0]   n_acc;
    logic [IW:0]   n_commit;

    logic [WAYS-1:0][IW-1:0] win_idx;
    logic [WAYS-1:0] win_valid, win_complete, win_mispredict, win_has_dest;
    logic [WAYS-1:0] byp_complete, byp_mispredict;

    // Allocation: accept as many of the requested ways as there are free
    // slots; slots freed by this cycle's commit are not reused until next cycle.
    assign free_count = (IW+1)'(ROB_SIZE) - count;
    assign n_req      = (IW+1)'(count_ones(32'(dispatch_valid)));
    assign n_commit   = (IW+1)'(count_ones(32'(commit_valid)));

    // A flush cycle allocates nothing; reset also blocks acceptance.
    always_comb begin
        n_acc = (n_req < free_count) ? n_req : free_count;
        if (except) n_acc = '0;
        for (int i = 0; i < WAYS; i++) begin
            dispatch_accept[i]  = reset && ((IW+1)'(i) < n_acc);
            dispatch_rob_idx[i] = tail + IW'(i);
        end
    end

    // Gather the head window, wrapping naturally through the pointer width.
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            win_idx[j]        = head + IW'(j);
            win_valid[j]      = entries[win_idx[j]].valid;
            win_complete[j]   = entries[win_idx[j]].complete;
            win_mispredict[j] = entries[win_idx[j]].mispredict;
            win_has_dest[j]   = entries[win_idx[j]].has_dest;
            commit_arf_idx[j] = entries[win_idx[j]].arf_idx;
            commit_prf_idx[j] = PW'(entries[win_idx[j]].prf_idx);
        end
    end

`ifdef ROB_CDB_COMMIT_BYPASS_EN
    // Same-cycle completion: match live CDB tags against the head window.
    always_comb begin
        byp_complete   = '0;
        byp_mispredict = '0;
        for (int j = 0; j < WAYS; j++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (cdb_valid[i] && cdb_rob_idx[i] == win_idx[j]) begin
                    byp_complete[j]   = 1'b1;
                    byp_mispredict[j] = byp_mispredict[j] | cdb_mispredict[i];
                end
            end
        end
    end
`else
    assign byp_complete   = '0;
    assign byp_mispredict = '0;
`endif

    rob_commit_select #(.WAYS(WAYS)) u_commit_select (
        .valid          (win_valid),
        .complete       (win_complete),
        .mispredict     (win_mispredict),
        .has_dest       (win_has_dest),
        .byp_complete   (byp_complete),
        .byp_mispredict (byp_mispredict),
        .commit_valid   (commit_valid),
        .commit_wr_en   (commit_wr_en),
        .except         (except)
    );

    // Pointer/count/entry update: flush wins, otherwise retire, complete, allocate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < ROB_SIZE; k++) entries[k] <= '0;
        end else if (except) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < ROB_SIZE; k++) begin
                entries[k].valid      <= 1'b0;
                entries[k].complete   <= 1'b0;
                entries[k].mispredict <= 1'b0;
            end
        end else begin
            head  <= head + IW'(n_commit);
            tail  <= tail + IW'(n_acc);
            count <= count + n_acc - n_commit;
            for (int j = 0; j < WAYS; j++)
                if (commit_valid[j]) entries[win_idx[j]].valid <= 1'b0;
            // Tags for empty slots are stale and dropped.
            for (int i = 0; i < WAYS; i++) begin
                if (cdb_valid[i] && entries[cdb_rob_idx[i]].valid) begin
                    entries[cdb_rob_idx[i]].complete <= 1'b1;
                    if (cdb_mispredict[i]) entries[cdb_rob_idx[i]].mispredict <= 1'b1;
                end
            end
            for (int i = 0; i < WAYS; i++) begin
                if (dispatch_accept[i]) begin
                    entries[dispatch_rob_idx[i]] <= '{valid:      1'b1,
                                                     complete:   1'b0,
                                                     mispredict: 1'b0,
                                                     has_dest:   dispatch_has_dest[i],
                                                     arf_idx:    dispatch_arf_idx[i],
                                                     prf_idx:    PRF_W'(dispatch_prf_idx[i])};
                end
            end
        end
    end

`ifdef DEBUG
    // Requests must be packed from way 0 upward.
    always_ff @(posedge clock) begin
        if (reset) assert ((dispatch_valid & (dispatch_valid + 1'b1)) == '0);
    end
`endif

endmodule
